// File: rtl/divider_array_scheduler.sv
// -----------------------------------------------------------------------------
// divider_array_scheduler
//
// Shares one combinational 16/8 restoring-array divider between two
// requesters. Requests are granted round-robin, operands are registered onto
// the array, held for SETTLE_CYCLES, and the array's quotient/remainder are
// captured and returned over a valid/ready response channel tagged with the
// requester ID.
//
// Optional feature macro: DIV_OVF_DETECT_EN
//   defined   : n[15:8] >= d (d != 0) short-circuits to q=r=8'hFF, ovf=1
//   undefined : resp_ovf tied 0, overflow cases run through the array
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   reqX_valid/ready/n/d       requester X operation channel (X = 0,1)
//   resp_valid/ready           response handshake
//   resp_id/q/r/dz/ovf         response payload
//   div_n/div_d                registered operands driven to the array
//   div_q/div_r                array results
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module divider_array_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [7:0]  resp_q,
  output logic [7:0]  resp_r,
  output logic        resp_dz,
  output logic        resp_ovf,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;       // last granted requester
  logic        resp_id_q, resp_id_d;
  logic [7:0]  resp_q_q, resp_q_d;
  logic [7:0]  resp_r_q, resp_r_d;
  logic        resp_dz_q, resp_dz_d;
  logic [15:0] div_n_q, div_n_d;
  logic [7:0]  div_d_q, div_d_d;

  logic        gnt0, gnt1, accept;
  logic [15:0] acc_n;
  logic [7:0]  acc_d;

  // A lone requester wins; on a tie the one not granted last wins.
  assign gnt0   = req0_valid & (~req1_valid | last_q);
  assign gnt1   = req1_valid & (~req0_valid | ~last_q);
  assign accept = (state_q == IDLE) & (gnt0 | gnt1);
  assign acc_n  = gnt1 ? req1_n : req0_n;
  assign acc_d  = gnt1 ? req1_d : req0_d;

`ifdef DIV_OVF_DETECT_EN
  logic resp_ovf_q, resp_ovf_d;
  logic ovf_hit;
  assign ovf_hit  = (acc_d != '0) && (acc_n[15:8] >= acc_d);
  assign resp_ovf = resp_ovf_q;
`else
  assign resp_ovf = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    resp_id_d = resp_id_q;
    resp_q_d  = resp_q_q;
    resp_r_d  = resp_r_q;
    resp_dz_d = resp_dz_q;
    div_n_d   = div_n_q;
    div_d_d   = div_d_q;
`ifdef DIV_OVF_DETECT_EN
    resp_ovf_d = resp_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_n_d   = acc_n;
          div_d_d   = acc_d;
          resp_id_d = gnt1;
          last_d    = gnt1;
          resp_dz_d = 1'b0;
`ifdef DIV_OVF_DETECT_EN
          resp_ovf_d = 1'b0;
`endif
          if (acc_d == '0) begin
            state_d   = RESP;
            resp_q_d  = '1;
            resp_r_d  = acc_n[7:0];
            resp_dz_d = 1'b1;
          end
`ifdef DIV_OVF_DETECT_EN
          else if (ovf_hit) begin
            state_d    = RESP;
            resp_q_d   = '1;
            resp_r_d   = '1;
            resp_ovf_d = 1'b1;
          end
`endif
          else begin
            state_d = BUSY;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          resp_q_d = div_q;
          resp_r_d = div_r;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      resp_id_q <= 1'b0;
      resp_q_q  <= '0;
      resp_r_q  <= '0;
      resp_dz_q <= 1'b0;
      div_n_q   <= '0;
      div_d_q   <= '0;
`ifdef DIV_OVF_DETECT_EN
      resp_ovf_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      resp_id_q <= resp_id_d;
      resp_q_q  <= resp_q_d;
      resp_r_q  <= resp_r_d;
      resp_dz_q <= resp_dz_d;
      div_n_q   <= div_n_d;
      div_d_q   <= div_d_d;
`ifdef DIV_OVF_DETECT_EN
      resp_ovf_q <= resp_ovf_d;
`endif
    end
  end

  assign req0_ready = (state_q == IDLE) & gnt0;
  assign req1_ready = (state_q == IDLE) & gnt1;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_q     = resp_q_q;
  assign resp_r     = resp_r_q;
  assign resp_dz    = resp_dz_q;
  assign div_n      = div_n_q;
  assign div_d      = div_d_q;

endmodule

// File: tb/tb_divider_array_scheduler.sv
// -----------------------------------------------------------------------------
// tb_divider_array_scheduler
//
// Directed self-checking bench for divider_array_scheduler with an exact
// 16/8 divider model standing in for the array (quotient truncated to 8 bits).
// Honours DIV_OVF_DETECT_EN for the overflow expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_divider_array_scheduler;

  localparam int unsigned SETTLE = 2;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_n;
  logic [7:0]  req0_d;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_n;
  logic [7:0]  req1_d;
  logic        resp_valid, resp_ready, resp_id, resp_dz, resp_ovf;
  logic [7:0]  resp_q, resp_r;
  logic [15:0] div_n;
  logic [7:0]  div_d, div_q, div_r;

  int checks = 0;
  int errors = 0;

  divider_array_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz), .resp_ovf(resp_ovf),
    .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r)
  );

  // Exact divider stand-in for the array.
  logic [15:0] model_q, model_r;
  always_comb begin
    model_q = '1;
    model_r = div_n;
    if (div_d != '0) begin
      model_q = div_n / {8'h00, div_d};
      model_r = div_n % {8'h00, div_d};
    end
    div_q = model_q[7:0];
    div_r = model_r[7:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one request, wait for its grant, pass the accept edge, drop valid.
  task automatic issue(input int id, input logic [15:0] n, input logic [7:0] d);
    int t;
    if (id == 0) begin req0_valid = 1'b1; req0_n = n; req0_d = d; end
    else         begin req1_valid = 1'b1; req1_n = n; req1_d = d; end
    #1;
    t = 0;
    while (((id == 0) ? !req0_ready : !req1_ready) && t < 20) begin step(); t++; end
    check("grant_seen", (id == 0) ? req0_ready : req1_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called just after the accept edge; lat counts edges from accept to resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 30) begin step(); lat++; end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_drop", resp_valid, 0);
  endtask

  int lat;
  logic [7:0] hold_q, hold_r;
  logic hold_id;

  initial begin
    req0_valid = 1'b0; req0_n = '0; req0_d = '0;
    req1_valid = 1'b0; req1_n = '0; req1_d = '0;
    resp_ready = 1'b0;
    rst = 1'b0;
    step();
    do_reset();

    // Reset values
    check("rst_resp_valid", resp_valid, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_payload", {resp_id, resp_q, resp_r, resp_dz, resp_ovf}, 0);
    check("rst_div", {div_n, div_d}, 0);

    // Single op: 1000 / 10
    issue(0, 16'd1000, 8'd10);
    check("single_div_n", div_n, 16'd1000);
    check("single_div_d", div_d, 8'd10);
    wait_resp(lat);
    check("single_lat", lat, SETTLE + 1);
    check("single_q", resp_q, 8'd100);
    check("single_r", resp_r, 8'd0);
    check("single_id", resp_id, 0);
    check("single_dz", resp_dz, 0);
    take_resp();

    // Divide by zero from requester 1
    issue(1, 16'h1234, 8'd0);
    wait_resp(lat);
    check("dz_lat", lat, 1);
    check("dz_q", resp_q, 8'hFF);
    check("dz_r", resp_r, 8'h34);
    check("dz_flag", resp_dz, 1);
    check("dz_ovf", resp_ovf, 0);
    check("dz_id", resp_id, 1);
    take_resp();

    // Tie arbitration from reset: 100/7 on req0, 200/9 on req1
    do_reset();
    req0_n = 16'd100; req0_d = 8'd7;
    req1_n = 16'd200; req1_d = 8'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = 0;
      while (!(req0_ready || req1_ready) && t < 20) begin step(); t++; end
      check("tie_grant", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      wait_resp(lat);
      check("tie_id", resp_id, i % 2);
      check("tie_q", resp_q, (i % 2 == 0) ? 8'd14 : 8'd22);
      check("tie_r", resp_r, 8'd2);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b0;
    step();

    // Backpressure with both requesters pending
    issue(0, 16'd777, 8'd13);  // 59 r 10
    wait_resp(lat);
    hold_q = resp_q; hold_r = resp_r; hold_id = resp_id;
    check("bp_q", resp_q, 8'd59);
    check("bp_r", resp_r, 8'd10);
    req0_valid = 1'b1; req0_n = 16'd50; req0_d = 8'd5;
    req1_valid = 1'b1; req1_n = 16'd60; req1_d = 8'd6;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", resp_valid, 1);
      check("bp_stable", {resp_id, resp_q, resp_r}, {hold_id, hold_q, hold_r});
      check("bp_ready", {req1_ready, req0_ready}, 2'b00);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_after_hs_valid", resp_valid, 0);
    check("bp_after_hs_grant", {req1_ready, req0_ready}, 2'b10);
    step();  // accept req1 (60/6)
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(lat);
    check("bp_next_id", resp_id, 1);
    check("bp_next_q", resp_q, 8'd10);
    take_resp();

    // Quotient overflow: 0x0A00 / 5
    issue(0, 16'h0A00, 8'd5);
    wait_resp(lat);
`ifdef DIV_OVF_DETECT_EN
    check("ovf_lat", lat, 1);
    check("ovf_q", resp_q, 8'hFF);
    check("ovf_r", resp_r, 8'hFF);
    check("ovf_flag", resp_ovf, 1);
`else
    check("ovf_lat", lat, SETTLE + 1);
    check("ovf_q", resp_q, 8'h00);
    check("ovf_r", resp_r, 8'h00);
    check("ovf_flag", resp_ovf, 0);
`endif
    check("ovf_dz", resp_dz, 0);
    take_resp();

    // Reset one cycle after accept
    issue(1, 16'd500, 8'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_payload", {resp_id, resp_q, resp_r, resp_dz, resp_ovf}, 0);
    check("mid_rst_div", {div_n, div_d}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_no_resp", resp_valid, 0);
    end
    issue(0, 16'd301, 8'd12);
    wait_resp(lat);
    check("post_rst_lat", lat, SETTLE + 1);
    check("post_rst_q", resp_q, 8'd25);
    check("post_rst_r", resp_r, 8'd1);
    take_resp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
